// File: rtl/boton_eventos.sv
// Turns four debounced button levels into queued press/release/repeat events.
// Each button feeds a one-deep pending slot; slots drain into a 4-entry show-ahead FIFO.
module boton_eventos #(
  parameter bit          Simulate    = 1'b0,
  parameter int unsigned TickDiv     = 500000,
  parameter int unsigned HoldTicks   = 50,
  parameter int unsigned RepeatTicks = 10
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] iPushBtn,
  input  logic       iEventAck,
  input  logic       iClearOverflow,
  output logic       oEventValid,
  output logic [3:0] oEventCode,
  output logic       oOverflow
);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  localparam int unsigned TICK_N    = Simulate ? 4 : TickDiv;
  localparam logic [19:0] TICK_LAST = 20'(TICK_N - 1);
  localparam logic [7:0]  HOLD_T    = 8'(HoldTicks);
  localparam logic [7:0]  REP_T     = 8'(RepeatTicks);
  localparam logic [1:0]  EV_PRESS   = 2'b00;
  localparam logic [1:0]  EV_RELEASE = 2'b01;
  localparam logic [1:0]  EV_REPEAT  = 2'b10;

  logic [3:0]  btn_q;
  logic [19:0] presc;
  logic        tick;
  logic [3:0]  slot_v;
  logic [1:0]  slot_t [4];
  logic [3:0]  drain;
  logic [3:0]  drop;
  logic [3:0]  fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        pop;
  logic        push;
  logic        can_push;
  logic [1:0]  sel;
  logic [3:0]  push_code;

  assign tick        = (presc == TICK_LAST);
  assign oEventValid = (count != 3'd0);
  assign oEventCode  = oEventValid ? fifo_mem[rd_ptr] : 4'd0;
  assign pop         = oEventValid && iEventAck;
  // A full FIFO can still take a slot when the head leaves in the same cycle.
  assign can_push    = (count != 3'd4) || pop;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      btn_q <= '0;
      presc <= '0;
    end else begin
      btn_q <= iPushBtn;
      presc <= tick ? 20'd0 : presc + 20'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      state_t     state;
      state_t     state_next;
      logic [7:0] cnt;
      logic [7:0] cnt_next;
      logic [7:0] cnt_inc;
      logic       press;
      logic       rel;
      logic       ev;
      logic [1:0] ev_type;
      logic       sv;
      logic [1:0] st;

      assign press   = iPushBtn[gi] & ~btn_q[gi];
      assign rel     = ~iPushBtn[gi] & btn_q[gi];
      assign cnt_inc = cnt + 8'd1;

      always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ev         = 1'b0;
        ev_type    = EV_PRESS;
        case (state)
          IDLE: begin
            if (press) begin
              state_next = HELD;
              cnt_next   = 8'd0;
              ev         = 1'b1;
              ev_type    = EV_PRESS;
            end
          end
          HELD, REPEAT: begin
            // Release is checked first so it suppresses a coincident repeat.
            if (rel) begin
              state_next = IDLE;
              cnt_next   = 8'd0;
              ev         = 1'b1;
              ev_type    = EV_RELEASE;
            end else if (tick) begin
              if (cnt_inc == ((state == HELD) ? HOLD_T : REP_T)) begin
                state_next = REPEAT;
                cnt_next   = 8'd0;
                ev         = 1'b1;
                ev_type    = EV_REPEAT;
              end else begin
                cnt_next = cnt_inc;
              end
            end
          end
          default: state_next = IDLE;
        endcase
      end

      always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
          state <= IDLE;
          cnt   <= '0;
          sv    <= 1'b0;
          st    <= '0;
        end else begin
          state <= state_next;
          cnt   <= cnt_next;
          if (ev && (!sv || drain[gi])) begin
            sv <= 1'b1;
            st <= ev_type;
          end else if (drain[gi]) begin
            sv <= 1'b0;
          end
        end
      end

      assign drop[gi]   = ev & sv & ~drain[gi];
      assign slot_v[gi] = sv;
      assign slot_t[gi] = st;
    end
  endgenerate

  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (slot_v[i]) sel = 2'(i);
    end
  end

  assign push      = (|slot_v) && can_push;
  assign push_code = {slot_t[sel], sel};

  always_comb begin
    drain = '0;
    if (push) drain[sel] = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      oOverflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_code;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      if (|drop)               oOverflow <= 1'b1;
      else if (iClearOverflow) oOverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_boton_eventos.sv
// Bench for boton_eventos: directed scenarios plus random button activity,
// compared every cycle against a queue-based event model.
module tb_boton_eventos;

  localparam int HOLD = 3;
  localparam int REP  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       ack;
  logic       clr;
  logic       valid;
  logic [3:0] code;
  logic       ovf;

  boton_eventos #(
    .Simulate(1'b1), .TickDiv(8), .HoldTicks(HOLD), .RepeatTicks(REP)
  ) dut (
    .Clock(clk), .Reset_n(rst_n), .iPushBtn(btn), .iEventAck(ack),
    .iClearOverflow(clr), .oEventValid(valid), .oEventCode(code), .oOverflow(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: tick phase, last sampled levels, hold bookkeeping, slots, queue.
  int         phase;
  bit         prev [4];
  bit         held [4];
  int         since [4];
  bit         rep [4];
  bit         sv [4];
  logic [1:0] st [4];
  logic [3:0] q [$];
  bit         m_ovf;

  task automatic model_reset();
    phase = 0;
    for (int i = 0; i < 4; i++) begin
      prev[i] = 0; held[i] = 0; since[i] = 0; rep[i] = 0; sv[i] = 0; st[i] = 2'b00;
    end
    q.delete();
    m_ovf = 0;
  endtask

  task automatic model_step();
    bit         tk;
    bit         ev [4];
    logic [1:0] et [4];
    bit         popm;
    int         mv;
    logic [3:0] mc;
    bit         set;
    tk    = (phase == 3);
    phase = (phase + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      ev[i] = 0;
      et[i] = 2'b00;
      if (!held[i] && btn[i] && !prev[i]) begin
        held[i] = 1; since[i] = 0; rep[i] = 0; ev[i] = 1; et[i] = 2'b00;
      end else if (held[i] && !btn[i] && prev[i]) begin
        held[i] = 0; ev[i] = 1; et[i] = 2'b01;
      end else if (held[i] && tk) begin
        since[i]++;
        if (since[i] == (rep[i] ? REP : HOLD)) begin
          ev[i] = 1; et[i] = 2'b10; since[i] = 0; rep[i] = 1;
        end
      end
      prev[i] = btn[i];
    end
    popm = (q.size() > 0) && ack;
    mv = -1;
    for (int i = 3; i >= 0; i--) if (sv[i]) mv = i;
    if (mv >= 0 && !(q.size() < 4 || popm)) mv = -1;
    mc = 4'd0;
    if (mv >= 0) begin
      mc = {st[mv], 2'(mv)};
      sv[mv] = 0;
    end
    set = 0;
    for (int i = 0; i < 4; i++) begin
      if (ev[i]) begin
        if (sv[i]) set = 1;
        else begin sv[i] = 1; st[i] = et[i]; end
      end
    end
    if (popm) void'(q.pop_front());
    if (mv >= 0) q.push_back(mc);
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] head;
    head = (q.size() > 0) ? q[0] : 4'd0;
    chk("valid", {3'b000, valid}, {3'b000, (q.size() > 0)});
    chk("code", code, head);
    chk("overflow", {3'b000, ovf}, {3'b000, m_ovf});
  endtask

  task automatic step(input logic [3:0] b, input logic a, input logic c);
    btn = b; ack = a; clr = c;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  int rep_t [$];
  int cyc;
  logic [3:0] rb;

  initial begin
    rst_n = 1'b0; btn = 4'd0; ack = 1'b0; clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    #2 rst_n = 1'b1;

    // Single press/release of button 2.
    step(4'b0100, 0, 0);
    chk("press_latency_valid", {3'b000, valid}, 4'd0);
    step(4'b0100, 0, 0);
    chk("press2_code", code, 4'b0010);
    step(4'b0100, 1, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    chk("release2_code", code, 4'b0110);
    step(4'b0000, 1, 0);
    chk("drained_valid", {3'b000, valid}, 4'd0);

    // Auto-repeat on button 1 with ack tied high.
    for (int k = 0; k < 40; k++) begin
      step(4'b0010, 1, 0);
      if (valid && code == 4'b1001) rep_t.push_back(k);
    end
    for (int k = 0; k < 4; k++) step(4'b0000, 1, 0);
    chk("repeat_seen", {3'b000, (rep_t.size() >= 3)}, 4'd1);
    for (int k = 1; k < rep_t.size(); k++)
      chk("repeat_spacing", 4'(rep_t[k] - rep_t[k-1]), 4'd8);

    // Simultaneous press of all four buttons.
    step(4'b1111, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, 1, 0);
      chk("simul_code", code, 4'(k));
    end
    for (int k = 0; k < 6; k++) step(4'b0000, 1, 0);

    // Full FIFO, overflow, clear-vs-set, push+pop while full.
    step(4'b0001, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0001, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0001, 0, 0);
    step(4'b0000, 0, 0);
    chk("overflow_set", {3'b000, ovf}, 4'd1);
    step(4'b0010, 0, 0);
    step(4'b0000, 0, 1);
    chk("clear_loses_to_set", {3'b000, ovf}, 4'd1);
    step(4'b0000, 0, 1);
    chk("clear_alone", {3'b000, ovf}, 4'd0);
    step(4'b0000, 1, 0);
    chk("full_pushpop_valid", {3'b000, valid}, 4'd1);
    chk("full_pushpop_head", code, 4'b0100);
    step(4'b0000, 1, 0);
    step(4'b0000, 1, 0);
    step(4'b0000, 1, 0);
    chk("fifth_is_press", code, 4'b0000);
    for (int k = 0; k < 4; k++) step(4'b0000, 1, 0);
    chk("after_drain", {3'b000, valid}, 4'd0);

    // Reset while button 3 is repeating with events queued.
    for (int k = 0; k < 24; k++) step(4'b1000, 0, 0);
    chk("queued_before_reset", {3'b000, (q.size() >= 2)}, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_valid_now", {3'b000, valid}, 4'd0);
    chk("reset_ovf_now", {3'b000, ovf}, 4'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_model();
    #2 rst_n = 1'b1;
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    chk("held_through_reset", code, 4'b0011);
    step(4'b1000, 1, 0);
    for (int k = 0; k < 3; k++) step(4'b0000, 1, 0);

    // Random button activity, acks and clears.
    rb = 4'd0;
    for (cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
      step(rb, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boton_eventos.md
# boton_eventos

Converts the four debounced push-button levels from the debouncer into a queued stream of discrete button events: press, release, and auto-repeat while held. Events are delivered one at a time through a valid/ack handshake to the control FSM downstream. A 4-entry FIFO with per-button pending slots absorbs bursts. A sticky overflow flag marks lost events.

## Interface
- Simulate, 0, when 1 the tick prescaler uses 4 instead of TickDiv
- TickDiv, 500000, Clock cycles per hold tick (10 ms at 50 MHz); range 2..2^20
- HoldTicks, 50, ticks held before the first repeat; range 1..255
- RepeatTicks, 10, ticks between subsequent repeats; range 1..255
- Clock  in  1  system clock; all state on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- iPushBtn  in  4  debounced button levels; 1 = pressed
- iEventAck  in  1  consumer accepts the head event when high together with oEventValid
- iClearOverflow  in  1  one-cycle pulse that clears oOverflow
- oEventValid  out  1  FIFO non-empty
- oEventCode  out  4  head event, {type[1:0], btn[1:0]}; type 00 = press, 01 = release, 10 = repeat
- oOverflow  out  1  sticky: at least one event was dropped

## Operation
- **Input register.** rBtnQ <= iPushBtn every cycle. On the same edge, a bit where iPushBtn != rBtnQ is an edge:
  - 0->1 is a press.
  - 1->0 is a release.
- **Per-button FSM.** States IDLE, HELD, REPEAT; 8-bit tick counter per button.
  - IDLE: on press, go to HELD, clear the counter, raise a press event.
  - HELD: count ticks. When the count reaches HoldTicks, raise a repeat event, clear the counter, go to REPEAT.
  - REPEAT: when the count reaches RepeatTicks, raise a repeat event and clear the counter.
  - HELD or REPEAT: on release, raise a release event and go to IDLE. A release in the same cycle as a repeat threshold wins; no repeat is raised.
- **Tick.** The prescaler counts 0..N-1, with N = Simulate ? 4 : TickDiv. It produces a one-cycle tick when the count equals N-1. It runs freely and is not synchronised to presses.
- **Pending slots.** Each button has one slot holding a valid bit and a 2-bit type. A raised event loads the slot.
  - If the slot is already valid and is not being drained in this cycle, the new event is dropped and oOverflow is set.
- **Arbiter.**
  - Each cycle it moves at most one valid slot into the FIFO, lowest button index first, if the FIFO is not full.
  - Exception: when the FIFO is full, a slot may still be moved if a pop happens in the same cycle.
  - A moved slot is cleared; it may reload from a new event in the same cycle.
- **FIFO.**
  - 4 entries, show-ahead; 3-bit count; 2-bit read and write pointers that wrap 3->0.
  - oEventCode shows the head entry; it is 0 when the FIFO is empty.
  - A pop happens when oEventValid and iEventAck are both high.
  - A push and a pop in the same cycle leave the count unchanged, including when the FIFO is full.
- **Overflow flag.** iClearOverflow clears oOverflow. If a set condition occurs in the same cycle, the set wins.

## Timing
- **Reset (Reset_n low, takes effect immediately):** outputs 0; rBtnQ, FIFO, slots, counters and prescaler cleared; all FSMs IDLE.
  - A button still held when reset is released produces a press event on the first clock after release.
- **Latency:** a press sampled at edge k loads the slot at edge k, is pushed into the FIFO at edge k+1, and oEventValid is high from edge k+1.
  - This latency holds when the FIFO and lower-index slots are empty.
- **Handshake:**
  - oEventCode is stable while oEventValid=1 and iEventAck=0.
  - iEventAck while oEventValid=0 is ignored.
  - Back-to-back acks drain one entry per cycle.
- **First repeat:** the first repeat arrives between HoldTicks-1 and HoldTicks tick periods after the press, because the tick phase is free-running.

## Test plan
- **Single press/release.** Reset with buttons 0; raise iPushBtn[2], wait, drop it.
  - Required: oEventCode 4'b0010 and valid at edge k+1; ack; then 4'b0110; valid drops after the second ack.
- **Auto-repeat.** Simulate=1, HoldTicks=3, RepeatTicks=2; hold button 1 for 40 cycles with ack tied high.
  - Required: press 4'b0001; first repeat 4'b1001 about 12 cycles later; further repeats every 8 cycles; release 4'b0101 after the button drops; no repeat in the release cycle.
- **Simultaneous press.** Press all four buttons in one cycle with ack high.
  - Required: codes 0000, 0001, 0010, 0011 on four consecutive cycles.
- **Full FIFO.** Ack low; button 0 press, release, press, release (FIFO full); press (slot 0 pending); release while the slot is still pending.
  - Required: oOverflow=1; after four acks the fifth code is 4'b0000 (press); the dropped release never appears.
- **Clear and boundaries.** Pulse iClearOverflow in the same cycle as a new overflow, then alone.
  - Required: the flag stays 1 after the first pulse and goes 0 after the second.
  - Also: a simultaneous push and pop while full keeps count 4, and pointers wrap with the order preserved.
- **Reset mid-operation.** Assert Reset_n low during REPEAT with 3 queued events while button 3 is held; release reset.
  - Required: oEventValid goes to 0 immediately; one cycle after release, code 4'b0011 (press) appears.
